fwd_hazard_unit: RTL

Parametrised successor to the EX-stage forwarding logic. It generates per-operand forwarding selects across NUM_FWD downstream stages, store-data forwarding, and load-use stalls. It also tracks one outstanding fixed-latency multicycle op (mul/div) with a scoreboard FSM that produces RAW, WAW and structural stalls plus a completion bypass. It sits beside the ID/EX register and drives the EX operand muxes and the pipeline stall/flush control.

---
 rtl/fwd_hazard_pkg.sv | 40 ++++
 rtl/mc_scoreboard.sv | 115 +++++++++++
 rtl/fwd_hazard_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_pkg.sv
// fwd_hazard_pkg: shared types, select constants and the stage-match helper for fwd_hazard_unit.
//   mc_state_t     : multicycle scoreboard state (McIdle, McBusy, McDone)
//   SEL_REGFILE    : select value for "read the register file"
//   sel_mc()       : select value for the multicycle completion bypass (NUM_FWD+1)
//   youngest_match : index (1-based) of the youngest stage writing addr, 0 when none
package fwd_hazard_pkg;

   typedef enum logic [1:0] {
      McIdle = 2'd0,
      McBusy = 2'd1,
      McDone = 2'd2
   } mc_state_t;

   // Upper bounds for the helper's fixed-width arguments; callers zero-extend into these.
   localparam int unsigned MAX_FWD   = 8;
   localparam int unsigned MAX_FWD_W = 3;
   localparam int unsigned MAX_RW    = 8;

   localparam int unsigned SEL_REGFILE = 0;

   function automatic int unsigned sel_mc(input int unsigned num_fwd);
      return num_fwd + 1;
   endfunction

   // Stage 1 is the youngest, so the first hit scanning upward wins. Register x0 never matches.
   function automatic int unsigned youngest_match(input logic [MAX_RW-1:0]         addr,
                                                  input logic [MAX_FWD-1:0]        valid,
                                                  input logic [MAX_FWD*MAX_RW-1:0] rd);
      int unsigned hit;
      hit = 0;
      for (int unsigned k = 0; k < MAX_FWD; k++) begin
         if (hit == 0 && valid[k] && rd[k*MAX_RW +: MAX_RW] != '0 &&
             rd[k*MAX_RW +: MAX_RW] == addr) begin
            hit = k + 1;
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/mc_scoreboard.sv
// mc_scoreboard: tracks one outstanding fixed-latency multicycle op and its stall terms.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_src_addr/used   : EX operand addresses and use flags (RAW check)
//   i_ex_rd/i_ex_wr   : EX destination and write flag (WAW check)
//   i_start/i_rd      : multicycle issue request and its destination
//   i_flush           : abort a pending op / block acceptance
//   i_hazard_stall    : combined stall from the top; a stalled start is not accepted
//   o_busy/o_done     : state is BUSY / DONE (DONE lasts one cycle)
//   o_mc_rd           : latched destination of the op
//   o_stall           : RAW | WAW | structural stall while BUSY
module mc_scoreboard
   import fwd_hazard_pkg::*;
#(
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned RW         = 5,
   parameter int unsigned MC_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC*RW-1:0] i_src_addr,
   input  logic [NUM_SRC-1:0]    i_src_used,
   input  logic [RW-1:0]         i_ex_rd,
   input  logic                  i_ex_wr,
   input  logic                  i_start,
   input  logic [RW-1:0]         i_rd,
   input  logic                  i_flush,
   input  logic                  i_hazard_stall,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [RW-1:0]         o_mc_rd,
   output logic                  o_stall
);

   // BUSY spans MC_LATENCY-1 cycles: counter runs MC_LATENCY-2 down to 0, then DONE.
   localparam int unsigned     CNT_W    = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LATENCY - 2);

   mc_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [RW-1:0]    r_mc_rd, w_mc_rd_nxt;
   logic             w_accept;
   logic             w_pending;
   logic             w_raw;
   logic             w_waw;
   logic             w_struct;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= McIdle;
         r_cnt   <= '0;
         r_mc_rd <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mc_rd <= w_mc_rd_nxt;
      end
   end

   assign w_accept = i_start & ~i_hazard_stall & ~i_flush;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mc_rd_nxt = r_mc_rd;
      case (r_state)
         McIdle: begin
            if (w_accept) begin
               w_state_nxt = McBusy;
               w_cnt_nxt   = CNT_INIT;
               w_mc_rd_nxt = i_rd;
            end
         end
         McBusy: begin
            if (i_flush) begin
               w_state_nxt = McIdle;
            end else if (r_cnt == '0) begin
               w_state_nxt = McDone;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         McDone: begin
            // The completing op is older than any flush, so DONE always finishes.
            if (w_accept) begin
               w_state_nxt = McBusy;
               w_cnt_nxt   = CNT_INIT;
               w_mc_rd_nxt = i_rd;
            end else begin
               w_state_nxt = McIdle;
            end
         end
         default: w_state_nxt = McIdle;
      endcase
   end

   assign w_pending = (r_state == McBusy) && (r_mc_rd != '0);

   always_comb begin
      w_raw = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_pending && i_src_used[i] && i_src_addr[i*RW +: RW] == r_mc_rd) begin
            w_raw = 1'b1;
         end
      end
   end

   assign w_waw    = w_pending && i_ex_wr && (i_ex_rd == r_mc_rd);
   assign w_struct = (r_state == McBusy) && i_start;

   assign o_stall = w_raw | w_waw | w_struct;
   assign o_busy  = (r_state == McBusy);
   assign o_done  = (r_state == McDone);
   assign o_mc_rd = r_mc_rd;

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand/store-data forwarding selects, load-use and multicycle stalls.
//   clk, rst_n               : clock, asynchronous active-low reset
//   ex_src_addr_i/used_i     : EX operand addresses and use flags
//   ex_rd_i/ex_wr_i          : EX destination and write flag
//   fwd_valid/rd/ready_i     : per downstream stage write flag, destination, value-available
//   mem_store_i/mem_rs2_i    : stage-1 store and its data register
//   mc_start_i/mc_rd_i       : multicycle op issue and destination
//   flush_i                  : kill younger instructions / abort pending op
//   fwd_sel_o/store_sel_o    : selects (0 regfile, k stage k, NUM_FWD+1 multicycle bypass)
//   hazard_stall_o           : hold IF/ID/EX, bubble into MEM
//   mc_busy_o/done_o/wb_rd_o : multicycle status and completion writeback destination
// Optional HAZARD_STATS_EN adds saturating stall_cnt_o, fwd_cnt_o, mc_cnt_o counters.
module fwd_hazard_unit
   import fwd_hazard_pkg::*;
#(
   parameter  int unsigned NUM_SRC    = 2,
   parameter  int unsigned NUM_FWD    = 2,
   parameter  int unsigned RW         = 5,
   parameter  int unsigned MC_LATENCY = 4,
   localparam int unsigned SW         = $clog2(NUM_FWD + 2)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC*RW-1:0] ex_src_addr_i,
   input  logic [NUM_SRC-1:0]    ex_src_used_i,
   input  logic [RW-1:0]         ex_rd_i,
   input  logic                  ex_wr_i,
   input  logic [NUM_FWD-1:0]    fwd_valid_i,
   input  logic [NUM_FWD*RW-1:0] fwd_rd_i,
   input  logic [NUM_FWD-1:0]    fwd_ready_i,
   input  logic                  mem_store_i,
   input  logic [RW-1:0]         mem_rs2_i,
   input  logic                  mc_start_i,
   input  logic [RW-1:0]         mc_rd_i,
   input  logic                  flush_i,
   output logic [NUM_SRC*SW-1:0] fwd_sel_o,
   output logic [SW-1:0]         store_sel_o,
   output logic                  hazard_stall_o,
   output logic                  mc_busy_o,
   output logic                  mc_done_o,
   output logic [RW-1:0]         mc_wb_rd_o
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]           stall_cnt_o,
   output logic [31:0]           fwd_cnt_o,
   output logic [31:0]           mc_cnt_o
`endif
);

   localparam int unsigned SEL_MC = sel_mc(NUM_FWD);

   logic [MAX_FWD-1:0]        w_valid_ext;
   logic [MAX_FWD-1:0]        w_ready_ext;
   logic [MAX_FWD*MAX_RW-1:0] w_rd_ext;
   logic [MAX_FWD-1:0]        w_st_valid;
   logic [MAX_RW-1:0]         w_src_ext [NUM_SRC];
   int unsigned               w_match   [NUM_SRC];
   int unsigned               w_st_match;
   logic                      w_load_use;
   logic                      w_mc_stall;
   logic                      w_mc_done;
   logic [RW-1:0]             w_mc_rd;

   always_comb begin
      w_valid_ext = '0;
      w_ready_ext = '0;
      w_rd_ext    = '0;
      for (int k = 0; k < NUM_FWD; k++) begin
         w_valid_ext[k]                 = fwd_valid_i[k];
         w_ready_ext[k]                 = fwd_ready_i[k];
         w_rd_ext[k*MAX_RW +: MAX_RW]   = MAX_RW'(fwd_rd_i[k*RW +: RW]);
      end
   end

   // Operand selects; a not-ready youngest match is a load-use hazard.
   always_comb begin
      fwd_sel_o  = '0;
      w_load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_src_ext[i] = MAX_RW'(ex_src_addr_i[i*RW +: RW]);
         w_match[i]   = youngest_match(w_src_ext[i], ex_src_used_i[i] ? w_valid_ext : '0,
                                       w_rd_ext);
         fwd_sel_o[i*SW +: SW] = SW'(SEL_REGFILE);
         if (w_match[i] != 0) begin
            fwd_sel_o[i*SW +: SW] = SW'(w_match[i]);
            if (!w_ready_ext[MAX_FWD_W'(w_match[i] - 1)]) begin
               w_load_use = 1'b1;
            end
         end else if (w_mc_done && ex_src_used_i[i] && w_mc_rd != '0 &&
                      ex_src_addr_i[i*RW +: RW] == w_mc_rd) begin
            fwd_sel_o[i*SW +: SW] = SW'(SEL_MC);
         end
      end
   end

   // Store data: stage 1 is the store itself, so only stages 2.. with a ready value qualify.
   always_comb begin
      w_st_valid    = w_valid_ext & w_ready_ext;
      w_st_valid[0] = 1'b0;
      w_st_match    = youngest_match(MAX_RW'(mem_rs2_i), w_st_valid, w_rd_ext);
      store_sel_o   = SW'(SEL_REGFILE);
      if (mem_store_i && mem_rs2_i != '0 && w_st_match != 0) begin
         store_sel_o = SW'(w_st_match);
      end
   end

   assign hazard_stall_o = ~flush_i & (w_load_use | w_mc_stall);

   mc_scoreboard #(
      .NUM_SRC    (NUM_SRC),
      .RW         (RW),
      .MC_LATENCY (MC_LATENCY)
   ) u_mc_scoreboard (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_src_addr     (ex_src_addr_i),
      .i_src_used     (ex_src_used_i),
      .i_ex_rd        (ex_rd_i),
      .i_ex_wr        (ex_wr_i),
      .i_start        (mc_start_i),
      .i_rd           (mc_rd_i),
      .i_flush        (flush_i),
      .i_hazard_stall (hazard_stall_o),
      .o_busy         (mc_busy_o),
      .o_done         (w_mc_done),
      .o_mc_rd        (w_mc_rd),
      .o_stall        (w_mc_stall)
   );

   assign mc_done_o  = w_mc_done;
   assign mc_wb_rd_o = w_mc_done ? w_mc_rd : '0;

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_fwd_cnt;
   logic [31:0] r_mc_cnt;
   logic        w_any_fwd;

   assign w_any_fwd = (|fwd_sel_o) | (|store_sel_o);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
         r_mc_cnt    <= '0;
      end else begin
         if (hazard_stall_o && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_any_fwd && r_fwd_cnt != '1)        r_fwd_cnt   <= r_fwd_cnt + 1'b1;
         if (w_mc_done && r_mc_cnt != '1)         r_mc_cnt    <= r_mc_cnt + 1'b1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign fwd_cnt_o   = r_fwd_cnt;
   assign mc_cnt_o    = r_mc_cnt;
`endif

endmodule
